// File: rtl/sump_tx_if.sv
// Handshake bundle between the capture controller, the sump_tx packer and
// the UART transmitter. The packer uses the slave view; the controller/UART
// side (or a bench standing in for both) uses the master view.
interface sump_tx_if;
   logic        tx_stb_i;
   logic        tx_sel_i;
   logic [31:0] data_i;
   logic [3:0]  grp_en_i;
   logic        tx_rdy_o;
   logic        tx_done_o;
   logic [7:0]  uart_data_o;
   logic        uart_stb_o;
   logic        uart_rdy_i;

   modport slave (
      input  tx_stb_i, tx_sel_i, data_i, grp_en_i, uart_rdy_i,
      output tx_rdy_o, tx_done_o, uart_data_o, uart_stb_o
   );

   modport master (
      output tx_stb_i, tx_sel_i, data_i, grp_en_i, uart_rdy_i,
      input  tx_rdy_o, tx_done_o, uart_data_o, uart_stb_o
   );
endinterface

// File: rtl/sump_tx.sv
// sump_tx: packs a 32-bit sample word (or the fixed device ID) into bytes,
// LSB first, skipping bytes of disabled channel groups.
module sump_tx #(
   parameter logic [31:0] ID_WORD = 32'h534C_4131
) (
   input  logic     clk_i,
   input  logic     rst_i,
   sump_tx_if.slave bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state;
   logic [3:0]  mask;
   logic [1:0]  idx;
   logic [31:0] word;
   logic        last;
   logic        rdy_r;
   logic        stb_r;
   logic [7:0]  byte_r;

   logic [31:0] acc_word;
   logic [3:0]  acc_mask;
   logic [3:0]  rest_mask;

   // Index of the lowest set bit of a byte mask (caller guarantees nonzero).
   function automatic logic [1:0] low_bit(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // True when exactly one byte remains (caller guarantees nonzero).
   function automatic logic single(input logic [3:0] m);
      return (m & (m - 4'd1)) == 4'd0;
   endfunction

   // Byte i of a word.
   function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
      return w[{i, 3'b000} +: 8];
   endfunction

   // Candidate word/mask at acceptance and the mask left after the current byte.
   always_comb begin
      acc_word  = bus.tx_sel_i ? ID_WORD : bus.data_i;
      acc_mask  = bus.tx_sel_i ? 4'b1111 : bus.grp_en_i;
      rest_mask = mask & ~(4'b0001 << idx);
   end

   // Outputs are plain register reads; done fires in the cycle the final byte
   // is actually taken, so it qualifies the registered "last" flag with the
   // UART ready. uart_stb_o itself never depends on uart_rdy_i.
   assign bus.tx_rdy_o    = rdy_r;
   assign bus.uart_stb_o  = stb_r;
   assign bus.uart_data_o = byte_r;
   assign bus.tx_done_o   = stb_r & last & bus.uart_rdy_i;

   // Packer FSM: accept a word in IDLE, walk the enabled bytes in SEND.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         mask   <= 4'b0000;
         idx    <= 2'd0;
         word   <= 32'h0;
         last   <= 1'b0;
         rdy_r  <= 1'b1;
         stb_r  <= 1'b0;
         byte_r <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               // An all-zero mask drops the word silently and stays idle.
               if (bus.tx_stb_i && acc_mask != 4'b0000) begin
                  word   <= acc_word;
                  mask   <= acc_mask;
                  idx    <= low_bit(acc_mask);
                  last   <= single(acc_mask);
                  byte_r <= pick(acc_word, low_bit(acc_mask));
                  stb_r  <= 1'b1;
                  rdy_r  <= 1'b0;
                  state  <= SEND;
               end
            end
            SEND: begin
               // Without uart_rdy_i everything holds, so the byte stays stable.
               if (bus.uart_rdy_i) begin
                  mask <= rest_mask;
                  if (rest_mask != 4'b0000) begin
                     idx    <= low_bit(rest_mask);
                     last   <= single(rest_mask);
                     byte_r <= pick(word, low_bit(rest_mask));
                  end else begin
                     last  <= 1'b0;
                     stb_r <= 1'b0;
                     rdy_r <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sump_tx.sv
// Bench for sump_tx: directed and randomized words checked byte-by-byte
// against a queue of expected bytes derived from word and enable mask.
module tb_sump_tx;

   localparam logic [31:0] ID = 32'h534C_4131;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   logic [7:0] exp_q[$];
   bit         rdy_pat[$];

   sump_tx_if bus();

   sump_tx #(.ID_WORD(ID)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if something never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Three idle cycles with no UART traffic.
   task automatic chk_idle(input string tag);
      repeat (3) begin
         chk({tag, "_rdy"}, bus.tx_rdy_o, 1);
         chk({tag, "_stb"}, bus.uart_stb_o, 0);
         chk({tag, "_done"}, bus.tx_done_o, 0);
         @(negedge clk);
      end
   endtask

   // Request one word and follow it to completion. Called at a negedge.
   // rdy_pat supplies uart_rdy_i per cycle; random when empty.
   // noise scribbles on the request inputs (and strobes) while busy.
   task automatic send_word(input bit sel, input logic [31:0] d, input logic [3:0] g,
                            input bit noise);
      logic [31:0] w;
      logic [3:0]  m;
      int          budget;
      bit          r;
      w = sel ? ID : d;
      m = sel ? 4'b1111 : g;
      exp_q.delete();
      for (int k = 0; k < 4; k++)
         if (m[k]) exp_q.push_back(w[8*k +: 8]);

      chk("rdy_before", bus.tx_rdy_o, 1);
      bus.tx_stb_i = 1'b1;
      bus.tx_sel_i = sel;
      bus.data_i   = d;
      bus.grp_en_i = g;
      @(negedge clk);
      bus.tx_stb_i = 1'b0;

      if (exp_q.size() == 0) begin
         chk_idle("drop");
         return;
      end

      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         if (rdy_pat.size() != 0) r = rdy_pat.pop_front();
         else r = 1'($urandom_range(0, 1));
         bus.uart_rdy_i = r;
         if (noise) begin
            bus.data_i   = $urandom;
            bus.grp_en_i = 4'($urandom);
            bus.tx_sel_i = 1'($urandom_range(0, 1));
            bus.tx_stb_i = 1'b1;
         end
         #1;
         chk("stb", bus.uart_stb_o, 1);
         chk("busy_rdy", bus.tx_rdy_o, 0);
         chk("byte", bus.uart_data_o, exp_q[0]);
         chk("done", bus.tx_done_o, (r && exp_q.size() == 1) ? 1 : 0);
         if (r) void'(exp_q.pop_front());
         @(negedge clk);
         bus.tx_stb_i = 1'b0;
         budget++;
      end
      chk("bytes_left", exp_q.size(), 0);
      chk("end_rdy", bus.tx_rdy_o, 1);
      chk("end_stb", bus.uart_stb_o, 0);
      chk("end_done", bus.tx_done_o, 0);
      bus.uart_rdy_i = 1'b1;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst          = 1'b1;
      bus.tx_stb_i = 1'b0;
      bus.tx_sel_i = 1'b0;
      bus.data_i   = 32'h0;
      bus.grp_en_i = 4'b0000;
      bus.uart_rdy_i = 1'b1;

      // Reset state.
      #1;
      chk("rst_rdy", bus.tx_rdy_o, 1);
      chk("rst_stb", bus.uart_stb_o, 0);
      chk("rst_data", bus.uart_data_o, 8'h00);
      chk("rst_done", bus.tx_done_o, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ID request, mask input ignored.
      repeat (4) rdy_pat.push_back(1'b1);
      send_word(1'b1, 32'h0, 4'b0000, 1'b0);

      // Full sample, inputs scrambled while sending.
      repeat (4) rdy_pat.push_back(1'b1);
      send_word(1'b0, 32'hDEADBEEF, 4'b1111, 1'b1);

      // Group skip and fully disabled word.
      repeat (2) rdy_pat.push_back(1'b1);
      send_word(1'b0, 32'h44332211, 4'b1010, 1'b0);
      send_word(1'b0, 32'h44332211, 4'b0000, 1'b0);

      // Backpressure pattern.
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      send_word(1'b0, 32'hA1B2C3D4, 4'b1111, 1'b0);

      // Busy strobes with another word during SEND.
      rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      send_word(1'b0, 32'h12345678, 4'b0111, 1'b1);
      chk_idle("after_busy");

      // Randomized words.
      for (int i = 0; i < 24; i++)
         send_word(1'($urandom_range(0, 3) == 0), $urandom, 4'($urandom),
                   1'($urandom_range(0, 1)));

      // Asynchronous reset after the second byte.
      bus.uart_rdy_i = 1'b1;
      bus.tx_sel_i   = 1'b1;
      bus.tx_stb_i   = 1'b1;
      @(negedge clk);
      bus.tx_stb_i = 1'b0;
      chk("pre_rst_b0", bus.uart_data_o, 8'h31);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_b2", bus.uart_data_o, 8'h4C);
      #2 rst = 1'b1;
      #1;
      chk("arst_rdy", bus.tx_rdy_o, 1);
      chk("arst_stb", bus.uart_stb_o, 0);
      chk("arst_data", bus.uart_data_o, 8'h00);
      chk("arst_done", bus.tx_done_o, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("post_rst");
      send_word(1'b1, 32'h0, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
